// File: rtl/data_memory_sync.sv
// rtl/data_memory_sync.sv - synchronous data memory with clear sweep and write-first forwarding; optional parity via DATA_MEM_PARITY_EN
module data_memory_sync #(
    parameter int              DW       = 8,
    parameter int              AW       = 8,
    parameter int              DEPTH    = 256,
    parameter logic [DW-1:0]   INIT_VAL = '0
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic [AW-1:0] DataAddress,
    input  logic [DW-1:0] DataMemIn,
    output logic          Ready,
    output logic [DW-1:0] DataMemOut,
    output logic          DataValid,
    output logic          AddrErr,
    output logic          ParityErr
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DATA_MEM_PARITY_EN
    localparam int SW = DW + 1;
`else
    localparam int SW = DW;
`endif
    // One extra bit so DEPTH == 2**AW is representable in the range compare
    localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   clr_ptr_q, clr_ptr_d;
    logic            ready_q, ready_d;
    logic [DW-1:0]   data_out_q, data_out_d;
    logic            data_valid_q, data_valid_d;
    logic            addr_err_q, addr_err_d;
    logic            parity_err_q, parity_err_d;

    logic [SW-1:0]   mem_q [0:DEPTH-1];
    logic            mem_we;
    logic [IW-1:0]   mem_waddr;
    logic [SW-1:0]   mem_wdata;

    logic            in_range;
    logic [IW-1:0]   acc_idx;
    logic [SW-1:0]   rd_word;
    logic            parity_mismatch;

    // Stored word format: data, plus even parity on top when parity is enabled
    function automatic logic [SW-1:0] encode(input logic [DW-1:0] d);
`ifdef DATA_MEM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    // Address decode and raw array read for the current request
    always_comb begin
        in_range = ({1'b0, DataAddress} < DEPTH_EXT);
        acc_idx  = DataAddress[IW-1:0];
        rd_word  = mem_q[acc_idx];
`ifdef DATA_MEM_PARITY_EN
        parity_mismatch = (^rd_word[DW-1:0]) != rd_word[DW];
`else
        parity_mismatch = 1'b0;
`endif
    end

    // Next-state, array write port and registered output computation
    always_comb begin
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        ready_d      = ready_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        addr_err_d   = 1'b0;
        parity_err_d = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = clr_ptr_q;
        mem_wdata    = encode(INIT_VAL);

        unique case (state_q)
            ST_CLEAR: begin
                // Requests are ignored while the sweep walks the whole array
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = encode(INIT_VAL);
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST_IDX) begin
                    state_d   = ST_RUN;
                    ready_d   = 1'b1;
                    clr_ptr_d = '0;
                end
            end
            ST_RUN: begin
                if ((MemRead || MemWrite) && !in_range) begin
                    addr_err_d = 1'b1;
                end
                if (MemWrite && in_range) begin
                    mem_we    = 1'b1;
                    mem_waddr = acc_idx;
                    mem_wdata = encode(DataMemIn);
                end
                if (MemRead) begin
                    data_valid_d = 1'b1;
                    if (!in_range) begin
                        data_out_d = INIT_VAL;
                    end else if (MemWrite) begin
                        // Write-first: the single address port means read and write always collide
                        data_out_d = DataMemIn;
                    end else begin
                        data_out_d   = rd_word[DW-1:0];
                        parity_err_d = parity_mismatch;
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ready_d = 1'b0;
            end
        endcase
    end

    // Control FSM and registered outputs, cleared asynchronously
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_CLEAR;
            clr_ptr_q    <= '0;
            ready_q      <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            ready_q      <= ready_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            addr_err_q   <= addr_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    // Storage array; contents are only defined once the clear sweep completes
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign Ready      = ready_q;
    assign DataMemOut = data_out_q;
    assign DataValid  = data_valid_q;
    assign AddrErr    = addr_err_q;
    assign ParityErr  = parity_err_q;

endmodule

// File: tb/tb_data_memory_sync.sv
// tb/tb_data_memory_sync.sv - self-checking bench for data_memory_sync
module tb_data_memory_sync;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mem_read = 1'b0;
    logic       mem_write = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] din = 8'h00;

    logic       ready, dv, ae, pe;
    logic [7:0] dout;
    logic       ready2, dv2, ae2, pe2;
    logic [7:0] dout2;

    int checks = 0;
    int passed = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    data_memory_sync #(.DW(8), .AW(8), .DEPTH(256), .INIT_VAL(8'h00)) dut (
        .CLK(clk), .Reset(rst), .MemRead(mem_read), .MemWrite(mem_write),
        .DataAddress(addr), .DataMemIn(din), .Ready(ready), .DataMemOut(dout),
        .DataValid(dv), .AddrErr(ae), .ParityErr(pe)
    );

    data_memory_sync #(.DW(8), .AW(8), .DEPTH(200), .INIT_VAL(8'h00)) dut2 (
        .CLK(clk), .Reset(rst), .MemRead(mem_read), .MemWrite(mem_write),
        .DataAddress(addr), .DataMemIn(din), .Ready(ready2), .DataMemOut(dout2),
        .DataValid(dv2), .AddrErr(ae2), .ParityErr(pe2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model of the 256-deep instance: sweep length, then a plain array
    logic [7:0] m_mem [256];
    int         m_sweep;
    bit         m_ready;
    logic [7:0] m_out;
    bit         m_valid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sweep = 0;
            m_ready = 1'b0;
            m_out   = 8'h00;
            m_valid = 1'b0;
        end else if (!m_ready) begin
            m_sweep++;
            if (m_sweep == 256) begin
                m_ready = 1'b1;
                for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
            end
        end else begin
            m_valid = mem_read;
            if (mem_read) m_out = mem_write ? din : m_mem[addr];
            if (mem_write) m_mem[addr] = din;
        end
    end

    // Every cycle out of reset, the main instance must match the model
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("ready", ready, m_ready);
            chk("data_valid", dv, m_valid);
            chk("data_out", dout, m_out);
            chk("addr_err", ae, 0);
`ifndef DATA_MEM_PARITY_EN
            chk("parity_err", pe, 0);
`endif
        end
    end

    task automatic op(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        din       = d;
        @(negedge clk);
    endtask

    // Called at a negedge right after reset release; counts negedges with Ready low
    task automatic count_sweep(output int lo, output int lo2);
        lo = 0;
        lo2 = 0;
        for (int n = 0; n < 600 && (!ready || !ready2); n++) begin
            #1;
            if (!ready) lo++;
            if (!ready2) lo2++;
            @(negedge clk);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ready"}, ready, 0);
        chk({tag, "_dout"}, dout, 0);
        chk({tag, "_valid"}, dv, 0);
        chk({tag, "_addr_err"}, ae, 0);
        chk({tag, "_parity_err"}, pe, 0);
        chk({tag, "_ready2"}, ready2, 0);
        chk({tag, "_dout2"}, dout2, 0);
        chk({tag, "_valid2"}, dv2, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lo, lo2;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero_outputs("reset");

        // Sweep length after release
        rst = 1'b0;
        cmp_en = 1'b1;
        count_sweep(lo, lo2);
        chk("sweep_len", lo, 256);
        chk("sweep_len_d200", lo2, 200);

        // Every address reads back as cleared
        for (int a = 0; a < 256; a++) begin
            op(1'b1, 1'b0, a[7:0], 8'h00);
            chk("clr_out", dout, 8'h00);
            chk("clr_valid", dv, 1);
            chk("clr_out_d200", dout2, 8'h00);
            chk("clr_valid_d200", dv2, 1);
            chk("clr_addr_err_d200", ae2, (a >= 200));
        end
        op(1'b0, 1'b0, 8'h00, 8'h00);
        chk("idle_valid", dv, 0);

        // Write then read
        op(1'b0, 1'b1, 8'h10, 8'hA5);
        chk("wr_no_valid", dv, 0);
        op(1'b1, 1'b0, 8'h10, 8'h00);
        chk("rd_a5", dout, 8'hA5);
        chk("rd_a5_valid", dv, 1);
        chk("rd_a5_d200", dout2, 8'hA5);

        // Write-first forwarding
        op(1'b1, 1'b1, 8'h20, 8'h3C);
        chk("fwd_3c", dout, 8'h3C);
        chk("fwd_valid", dv, 1);
        op(1'b1, 1'b0, 8'h20, 8'h00);
        chk("fwd_stored", dout, 8'h3C);

        // Out-of-range handling on the 200-deep instance
        op(1'b0, 1'b1, 8'hF0, 8'h77);
        chk("oor_wr_addr_err", ae2, 1);
        chk("oor_wr_valid", dv2, 0);
        op(1'b1, 1'b0, 8'hF0, 8'h00);
        chk("oor_rd_out", dout2, 8'h00);
        chk("oor_rd_addr_err", ae2, 1);
        chk("oor_rd_valid", dv2, 1);
        chk("inrange_256_f0", dout, 8'h77);
        op(1'b0, 1'b0, 8'h00, 8'h00);
        chk("oor_pulse_end", ae2, 0);
        chk("hold_out", dout, 8'h77);
        chk("hold_valid", dv, 0);
        op(1'b0, 1'b1, 8'hC7, 8'h5A);
        chk("last_wr_addr_err", ae2, 0);
        op(1'b1, 1'b0, 8'hC7, 8'h00);
        chk("last_rd_out", dout2, 8'h5A);
        chk("last_rd_addr_err", ae2, 0);
        op(1'b0, 1'b1, 8'hC8, 8'h11);
        chk("first_oor_wr", ae2, 1);
        op(1'b1, 1'b0, 8'hC8, 8'h00);
        chk("first_oor_rd_out", dout2, 8'h00);
        chk("first_oor_rd_err", ae2, 1);

        // Parity
`ifdef DATA_MEM_PARITY_EN
        op(1'b0, 1'b1, 8'h05, 8'h0F);
        dut.mem_q[5][8] = ~dut.mem_q[5][8];
        op(1'b1, 1'b0, 8'h05, 8'h00);
        chk("par_out", dout, 8'h0F);
        chk("par_valid", dv, 1);
        chk("par_err", pe, 1);
        op(1'b1, 1'b1, 8'h05, 8'h0F);
        chk("par_fwd_clean", pe, 0);
`else
        op(1'b0, 1'b1, 8'h05, 8'h0F);
        op(1'b1, 1'b0, 8'h05, 8'h00);
        chk("nopar_out", dout, 8'h0F);
        chk("nopar_err", pe, 0);
        chk("nopar_err_d200", pe2, 0);
`endif

        // Async reset during a read; requests during the sweep are ignored
        mem_read = 1'b1;
        mem_write = 1'b0;
        addr = 8'h10;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_zero_outputs("rst_mid_read");
        mem_write = 1'b1;
        addr = 8'h30;
        din = 8'hEE;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        count_sweep(lo, lo2);
        chk("sweep_len_after_read_rst", lo, 256);
        op(1'b1, 1'b0, 8'h30, 8'h00);
        chk("sweep_ignores_wr", dout, 8'h00);
        op(1'b1, 1'b0, 8'h10, 8'h00);
        chk("cleared_10", dout, 8'h00);

        // Async reset at sweep cycle 100
        op(1'b0, 1'b1, 8'h40, 8'h99);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_write = 1'b0;
        repeat (100) @(negedge clk);
        #1 rst = 1'b1;
        #1 chk_zero_outputs("rst_mid_sweep");
        @(negedge clk);
        rst = 1'b0;
        count_sweep(lo, lo2);
        chk("sweep_len_restart", lo, 256);
        op(1'b1, 1'b0, 8'h40, 8'h00);
        chk("cleared_40", dout, 8'h00);
        chk("cleared_40_valid", dv, 1);
        op(1'b0, 1'b0, 8'h00, 8'h00);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
